// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, LED vector type and the selector-to-LED decode
package decode_pkg;
  localparam int SEL_W = 2;
  localparam int LED_W = 4;
  typedef logic [LED_W-1:0] led_t;
  function automatic led_t onehot_dec(input logic [SEL_W-1:0] sel);
    return led_t'(1) << sel;
  endfunction
endpackage

// File: rtl/sync_bus.sv
// sync_bus: generic multi-bit flop chain for bringing an async bus into sys_clk
module sync_bus #(
  parameter int WIDTH = 2,
  parameter int STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r [STAGES];
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      for (int i = 0; i < STAGES; i++) r[i] <= '0;
    end else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
    end
  assign q = r[STAGES-1];
endmodule

// File: rtl/decode_24.sv
// decode_24: registered 2-to-4 LED decoder behind an optional input synchronizer
module decode_24
  import decode_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [SEL_W-1:0] a,
  output logic [LED_W-1:0] led
);
  logic [SEL_W-1:0] s;
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("decode_24: SYNC_STAGES must be within 0..4");
  end
  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = a;
  end else begin : g_sync
    sync_bus #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sync (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .d(a),
      .q(s)
    );
  end
  // Any 2-bit code decodes to exactly one lit LED, so intermediate codes stay one-hot
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) led <= {LED_W{LED_ACTIVE_LOW}};
    else led <= onehot_dec(s) ^ {LED_W{LED_ACTIVE_LOW}};
endmodule

// File: tb/tb_decode_24.sv
// tb_decode_24: directed and random checks of decode_24 in synced, inverted and bypass builds
module tb_decode_24;
  logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1;
  logic [1:0] a = 2'b11;
  logic [3:0] led0, led1, led2;
  int checks = 0, failures = 0, hold = 0;
  logic [3:0] tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] vals [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [1:0] p, h0, h1, h2;

  decode_24 #(.SYNC_STAGES(2), .LED_ACTIVE_LOW(1'b0)) u0 (.sys_clk(clk), .sys_rst_n(rst_n), .a(a), .led(led0));
  decode_24 #(.SYNC_STAGES(2), .LED_ACTIVE_LOW(1'b1)) u1 (.sys_clk(clk), .sys_rst_n(rst_n), .a(a), .led(led1));
  decode_24 #(.SYNC_STAGES(0), .LED_ACTIVE_LOW(1'b0)) u2 (.sys_clk(clk), .sys_rst_n(rst_n), .a(a), .led(led2));

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_0", led0, 4'b0000);
    chk("rst_async_1", led1, 4'b1111);
    chk("rst_async_2", led2, 4'b0000);
    a = 2'b00;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_0", led0, 4'b0000);
    chk("rst_clk_1", led1, 4'b1111);
    chk("rst_clk_2", led2, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("rel_0", led0, 4'b0001);
    chk("rel_1", led1, 4'b1110);
    chk("rel_2", led2, 4'b0001);
    tick;
    tick;
    p = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) a = vals[k];
      tick;
      chk("sweep_e1_0", led0, tbl[p]);
      chk("sweep_e1_1", led1, ~tbl[p]);
      chk("sweep_e1_2", led2, tbl[vals[k]]);
      tick;
      chk("sweep_e2_0", led0, tbl[p]);
      chk("sweep_e2_1", led1, ~tbl[p]);
      p = vals[k];
    end
    tick;
    chk("sweep_last_0", led0, 4'b0001);
    chk("sweep_last_1", led1, 4'b1110);
    @(negedge clk) a = 2'b10;
    repeat (3) tick;
    chk("pre_mid_0", led0, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_0", led0, 4'b0000);
    chk("mid_rst_1", led1, 4'b1111);
    chk("mid_rst_2", led2, 4'b0000);
    #6 rst_n = 1'b1;
    tick;
    chk("refill_e1_0", led0, 4'b0001);
    chk("refill_e1_1", led1, 4'b1110);
    chk("refill_e1_2", led2, 4'b0100);
    tick;
    chk("refill_e2_0", led0, 4'b0001);
    tick;
    chk("refill_e3_0", led0, 4'b0100);
    chk("refill_e3_1", led1, 4'b1011);
    @(negedge clk) a = 2'b01;
    tick;
    chk("byp_01", led2, 4'b0010);
    @(negedge clk) a = 2'b11;
    #1;
    chk("byp_no_comb", led2, 4'b0010);
    tick;
    chk("byp_11", led2, 4'b1000);
    tick;
    tick;
    h0 = a;
    h1 = a;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (hold == 0) begin
        a = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 3);
      end
      hold--;
      @(posedge clk);
      h2 = h1;
      h1 = h0;
      h0 = a;
      #1;
      chk("rnd_sync", led0, tbl[h2]);
      chk("rnd_inv", led1, ~tbl[h2]);
      chk("rnd_byp", led2, tbl[h0]);
      checks++;
      assert ($countones(led0) == 1) else begin
        failures++;
        $error("FAIL rnd_onehot got=%b exp=one-hot", led0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
